// File: rtl/motor_relu_seq_ctrl_if.sv
// Frame handshake bundle for the shared-lane ReLU sequencer.
// "slave" is the sequencer side; "master" drives frames in and drains results.
interface motor_relu_seq_ctrl_if #(
  parameter int unsigned W  = 21,
  parameter int unsigned N  = 4,
  parameter int unsigned CW = $clog2(N + 1)
);
  logic [N*W-1:0] in_data;
  logic           in_valid;
  logic           in_ready;
  logic [N*W-1:0] out_data;
  logic           out_valid;
  logic           out_ready;
  logic           busy;
  logic [CW-1:0]  clip_cnt;

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid, busy, clip_cnt
  );

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid, busy, clip_cnt
  );
endinterface

// File: rtl/motor_relu_seq_ctrl.sv
// Time-multiplexed ReLU stage: one frame of N activations through one lane, one element per clock.
// Optional clip counter enabled by defining MOTOR_RELU_CLIPCNT_EN; otherwise clip_cnt reads 0.
module motor_relu_seq_ctrl #(
  parameter int unsigned W  = 21,
  parameter int unsigned N  = 4,
  parameter int unsigned CW = $clog2(N + 1)
) (
  input logic                  ap_clk,
  input logic                  ap_rst,
  motor_relu_seq_ctrl_if.slave bus
);
  localparam int unsigned IW = $clog2(N);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e         state_q, state_d;
  logic [N*W-1:0] buf_q, buf_d;
  logic [N*W-1:0] out_q, out_d;
  logic [IW-1:0]  idx_q, idx_d;
  logic           accept;
  logic           last;
  logic [W-1:0]   lane_x;
  logic [W-1:0]   lane_y;

  assign accept = bus.in_valid && bus.in_ready;
  assign last   = (idx_q == IW'(N - 1));
  assign lane_x = buf_q[int'(idx_q) * int'(W) +: W];
  // Strictly positive passes through; zero and all negatives clamp to 0.
  assign lane_y = (!lane_x[W-1] && |lane_x[W-2:0]) ? {1'b0, lane_x[W-2:0]} : '0;

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      state_q <= StIdle;
      buf_q   <= '0;
      out_q   <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
      out_q   <= out_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (bus.in_valid) state_d = StRun;
      StRun:  if (last) state_d = StDone;
      StDone: if (bus.out_ready) state_d = bus.in_valid ? StRun : StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    bus.in_ready  = (state_q == StIdle) || ((state_q == StDone) && bus.out_ready);
    bus.out_valid = (state_q == StDone);
    bus.busy      = (state_q == StRun);
    bus.out_data  = out_q;
  end

  always_comb begin
    buf_d = buf_q;
    out_d = out_q;
    idx_d = idx_q;
    if (accept) begin
      buf_d = bus.in_data;
      idx_d = '0;
    end else if (state_q == StRun) begin
      out_d[int'(idx_q) * int'(W) +: W] = lane_y;
      idx_d = last ? '0 : idx_q + 1'b1;
    end
  end

`ifdef MOTOR_RELU_CLIPCNT_EN
  logic [CW-1:0] clip_run_q, clip_run_d;
  logic [CW-1:0] clip_q, clip_d;
  logic          clipped;

  assign clipped = (lane_y == '0);

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      clip_run_q <= '0;
      clip_q     <= '0;
    end else begin
      clip_run_q <= clip_run_d;
      clip_q     <= clip_d;
    end
  end

  always_comb begin
    clip_run_d = clip_run_q;
    clip_d     = clip_q;
    if (accept) begin
      clip_run_d = '0;
    end else if (state_q == StRun) begin
      clip_run_d = clip_run_q + CW'(clipped);
      if (last) clip_d = clip_run_q + CW'(clipped);
    end
  end

  assign bus.clip_cnt = clip_q;
`else
  assign bus.clip_cnt = {CW{1'b0}};
`endif

endmodule

// File: tb/tb_motor_relu_seq_ctrl.sv
// Directed bench for motor_relu_seq_ctrl: vector table plus backpressure, back-to-back and reset.
module tb_motor_relu_seq_ctrl;
  localparam int unsigned W  = 21;
  localparam int unsigned N  = 4;
  localparam int unsigned CW = $clog2(N + 1);

  logic ap_clk = 1'b0;
  logic ap_rst = 1'b1;
  int   total  = 0;
  int   bad    = 0;

  motor_relu_seq_ctrl_if #(.W(W), .N(N), .CW(CW)) bif ();

  motor_relu_seq_ctrl #(.W(W), .N(N), .CW(CW)) dut (
    .ap_clk (ap_clk),
    .ap_rst (ap_rst),
    .bus    (bif)
  );

  always #5 ap_clk = ~ap_clk;

  typedef struct {
    logic [N*W-1:0] din;
    logic [N*W-1:0] dexp;
    int             clips;
  } vec_t;

  vec_t vecs[5];

  function automatic logic [N*W-1:0] pk(logic [W-1:0] e0, logic [W-1:0] e1,
                                        logic [W-1:0] e2, logic [W-1:0] e3);
    return {e3, e2, e1, e0};
  endfunction

  function automatic logic [CW-1:0] clip_exp(int c);
`ifdef MOTOR_RELU_CLIPCNT_EN
    return CW'(c);
`else
    return (c < 0) ? CW'(1) : CW'(0);
`endif
  endfunction

  task automatic check(string name, logic [127:0] act, logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Called just after an accept edge; ends at the negedge of the first DONE cycle.
  task automatic finish_frame(string name, logic [N*W-1:0] dexp, int clips);
    for (int c = 0; c < int'(N); c++) begin
      @(negedge ap_clk);
      check({name, " busy"}, 128'(bif.busy), 128'(1));
      check({name, " early valid"}, 128'(bif.out_valid), 128'(0));
      @(posedge ap_clk);
    end
    @(negedge ap_clk);
    check({name, " out_valid"}, 128'(bif.out_valid), 128'(1));
    check({name, " busy low"}, 128'(bif.busy), 128'(0));
    check({name, " out_data"}, 128'(bif.out_data), 128'(dexp));
    check({name, " clip_cnt"}, 128'(bif.clip_cnt), 128'(clip_exp(clips)));
  endtask

  task automatic start_frame(string name, logic [N*W-1:0] din);
    @(negedge ap_clk);
    bif.in_data  = din;
    bif.in_valid = 1'b1;
    #1;
    check({name, " in_ready"}, 128'(bif.in_ready), 128'(1));
    @(posedge ap_clk);
    #1 bif.in_valid = 1'b0;
  endtask

  initial begin
    time t_prev;
    time t_now;

    vecs[0] = '{pk(21'h000100, 21'h1FFFFF, 21'h000000, 21'h0FFFFF),
                pk(21'h000100, 21'h000000, 21'h000000, 21'h0FFFFF), 2};
    vecs[1] = '{pk(21'h100000, 21'h100000, 21'h100000, 21'h100000), '0, 4};
    vecs[2] = '{pk(21'h000001, 21'h000001, 21'h000001, 21'h000001),
                pk(21'h000001, 21'h000001, 21'h000001, 21'h000001), 0};
    vecs[3] = '{pk(21'h000005, 21'h1FFF00, 21'h0ABCDE, 21'h100001),
                pk(21'h000005, 21'h000000, 21'h0ABCDE, 21'h000000), 2};
    vecs[4] = '{pk(21'h000000, 21'h000000, 21'h000000, 21'h000002),
                pk(21'h000000, 21'h000000, 21'h000000, 21'h000002), 3};

    bif.in_data   = '0;
    bif.in_valid  = 1'b0;
    bif.out_ready = 1'b1;

    // Reset state
    #12;
    check("rst in_ready", 128'(bif.in_ready), 128'(1));
    check("rst out_valid", 128'(bif.out_valid), 128'(0));
    check("rst busy", 128'(bif.busy), 128'(0));
    check("rst out_data", 128'(bif.out_data), 128'(0));
    check("rst clip_cnt", 128'(bif.clip_cnt), 128'(0));
    @(negedge ap_clk);
    ap_rst = 1'b0;

    // Table-driven frames, out_ready held high
    for (int i = 0; i < 5; i++) begin
      start_frame($sformatf("vec%0d", i), vecs[i].din);
      finish_frame($sformatf("vec%0d", i), vecs[i].dexp, vecs[i].clips);
      @(posedge ap_clk);
    end
    @(negedge ap_clk);
    check("back to idle", 128'(bif.in_ready), 128'(1));

    // Backpressure in DONE with a pending new frame
    bif.out_ready = 1'b0;
    start_frame("bp", vecs[0].din);
    finish_frame("bp", vecs[0].dexp, vecs[0].clips);
    bif.in_data  = vecs[3].din;
    bif.in_valid = 1'b1;
    for (int c = 0; c < 10; c++) begin
      #1;
      check("bp hold valid", 128'(bif.out_valid), 128'(1));
      check("bp hold data", 128'(bif.out_data), 128'(vecs[0].dexp));
      check("bp hold clip", 128'(bif.clip_cnt), 128'(clip_exp(vecs[0].clips)));
      check("bp in_ready low", 128'(bif.in_ready), 128'(0));
      @(negedge ap_clk);
    end
    bif.out_ready = 1'b1;
    #1 check("bp in_ready comb", 128'(bif.in_ready), 128'(1));
    @(posedge ap_clk);
    #1 bif.in_valid = 1'b0;
    finish_frame("bp next", vecs[3].dexp, vecs[3].clips);
    @(posedge ap_clk);

    // Back-to-back through DONE->RUN, period N+1
    @(negedge ap_clk);
    bif.in_data  = vecs[2].din;
    bif.in_valid = 1'b1;
    @(posedge ap_clk);
    t_prev = 0;
    for (int f = 0; f < 3; f++) begin
      finish_frame($sformatf("b2b%0d", f), vecs[2+f].dexp, vecs[2+f].clips);
      t_now = $time;
      if (f > 0) check("b2b period", 128'(t_now - t_prev), 128'(10 * (N + 1)));
      t_prev = t_now;
      if (f < 2) begin
        bif.in_data = vecs[3+f].din;
        #1 check("b2b in_ready", 128'(bif.in_ready), 128'(1));
      end else begin
        bif.in_valid = 1'b0;
      end
      @(posedge ap_clk);
    end

    // Asynchronous reset mid-frame, idx == 2
    start_frame("rst mid", vecs[1].din);
    @(posedge ap_clk);
    @(posedge ap_clk);
    #2 ap_rst = 1'b1;
    #1;
    check("mid rst out_valid", 128'(bif.out_valid), 128'(0));
    check("mid rst busy", 128'(bif.busy), 128'(0));
    check("mid rst out_data", 128'(bif.out_data), 128'(0));
    check("mid rst in_ready", 128'(bif.in_ready), 128'(1));
    check("mid rst clip_cnt", 128'(bif.clip_cnt), 128'(0));
    @(negedge ap_clk);
    ap_rst = 1'b0;
    start_frame("post rst", vecs[4].din);
    finish_frame("post rst", vecs[4].dexp, vecs[4].clips);
    @(posedge ap_clk);
    @(negedge ap_clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
